ex_stage: RTL

- Execute stage; the reading end of the ID/EX pipeline buffer.
- Consumes the decoded bundle (control, pc, rs, rt, x, rd) and performs the ALU operation.
- Resolves branches and jumps against a registered Z/N flag pair, squashes wrong-path instructions, and registers results into the EX/MEM boundary.
- Honours a stall from downstream.

---
 rtl/ex_stage_pkg.sv | 22 ++
 rtl/ex_alu.sv | 26 ++
 rtl/ex_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: datapath widths, ALU operation
// encodings and branch condition selectors.
package ex_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 6;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_NEG   = 3'b100,
        ALU_PASSB = 3'b101,
        ALU_PCADD = 3'b110,
        ALU_PASSA = 3'b111
    } alu_op_e;

    localparam logic BTYPE_Z = 1'b0;
    localparam logic BTYPE_N = 1'b1;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the execute stage; all arithmetic wraps mod 2^32.
module ex_alu
    import ex_stage_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_pc,
    input  alu_op_e           i_op,
    output logic [DATA_W-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:   o_result = i_a + i_b;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_OR:    o_result = i_a | i_b;
            ALU_NEG:   o_result = '0 - i_a;
            ALU_PASSB: o_result = i_b;
            ALU_PCADD: o_result = i_pc + i_b;
            ALU_PASSA: o_result = i_a;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolution against registered Z/N flags,
// wrong-path squashing and the EX/MEM pipeline register.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned SHADOW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_ctrl_regwrt,
    input  logic              in_ctrl_branch,
    input  logic              in_ctrl_btype,
    input  logic              in_ctrl_jump,
    input  logic              in_ctrl_memtoreg,
    input  logic              in_ctrl_memrd,
    input  logic              in_ctrl_memwrt,
    input  logic [2:0]        in_ctrl_aluop,
    input  logic              in_ctrl_alusrc,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_rs,
    input  logic [DATA_W-1:0] in_rt,
    input  logic [DATA_W-1:0] in_x,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_stall,
    output logic              out_valid,
    output logic              out_ctrl_regwrt,
    output logic              out_ctrl_memtoreg,
    output logic              out_ctrl_memrd,
    output logic              out_ctrl_memwrt,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_wdata,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_redirect,
    output logic [DATA_W-1:0] out_redirect_pc
);

    localparam logic [2:0] SQ_LOAD = 3'(SHADOW);

    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;
    logic              w_eff;
    logic              w_cond;
    logic              w_taken;
    logic              w_flag_upd;

    logic              r_valid;
    logic              r_regwrt;
    logic              r_memtoreg;
    logic              r_memrd;
    logic              r_memwrt;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_wdata;
    logic [REG_W-1:0]  r_rd;
    logic              r_redirect;
    logic [DATA_W-1:0] r_redirect_pc;
    logic              r_z;
    logic              r_n;
    logic [2:0]        r_squash;

    assign w_b = in_ctrl_alusrc ? in_x : in_rt;

    ex_alu u_alu (
        .i_a      (in_rs),
        .i_b      (w_b),
        .i_pc     (in_pc),
        .i_op     (alu_op_e'(in_ctrl_aluop)),
        .o_result (w_alu)
    );

    // Only instructions outside the wrong-path shadow may redirect or touch flags.
    assign w_eff      = in_valid & (r_squash == '0);
    assign w_cond     = (in_ctrl_btype == BTYPE_N) ? r_n : r_z;
    assign w_taken    = w_eff & (in_ctrl_jump | (in_ctrl_branch & w_cond));
    assign w_flag_upd = w_eff & in_ctrl_regwrt & ~in_ctrl_memtoreg
                        & ~in_ctrl_branch & ~in_ctrl_jump;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_regwrt      <= 1'b0;
            r_memtoreg    <= 1'b0;
            r_memrd       <= 1'b0;
            r_memwrt      <= 1'b0;
            r_alu         <= '0;
            r_wdata       <= '0;
            r_rd          <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_z           <= 1'b0;
            r_n           <= 1'b0;
            r_squash      <= '0;
        end else if (in_stall) begin
            r_redirect    <= 1'b0;
        end else begin
            r_valid    <= w_eff;
            r_regwrt   <= w_eff & in_ctrl_regwrt;
            r_memtoreg <= in_ctrl_memtoreg;
            r_memrd    <= w_eff & in_ctrl_memrd;
            r_memwrt   <= w_eff & in_ctrl_memwrt;
            r_alu      <= w_alu;
            r_wdata    <= in_rt;
            r_rd       <= in_rd;
            r_redirect <= w_taken;
            // Bubbles do not consume shadow slots; only real instructions do.
            if (w_taken) begin
                r_redirect_pc <= in_rs;
                r_squash      <= SQ_LOAD;
            end else if (in_valid && (r_squash != '0)) begin
                r_squash      <= r_squash - 3'd1;
            end
            if (w_flag_upd) begin
                r_z <= (w_alu == '0);
                r_n <= w_alu[DATA_W-1];
            end
        end
    end

    assign out_valid         = r_valid;
    assign out_ctrl_regwrt   = r_regwrt;
    assign out_ctrl_memtoreg = r_memtoreg;
    assign out_ctrl_memrd    = r_memrd;
    assign out_ctrl_memwrt   = r_memwrt;
    assign out_alu           = r_alu;
    assign out_wdata         = r_wdata;
    assign out_rd            = r_rd;
    assign out_redirect      = r_redirect;
    assign out_redirect_pc   = r_redirect_pc;

endmodule
